// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO block: register map, address window,
// bus request payload and small helpers for byte lanes and the pad oeb pattern.
package wb_gpio_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned OEB_MAX_W = 64;

    localparam logic [IDX_W-1:0] REG_OUT      = 3'd0;
    localparam logic [IDX_W-1:0] REG_IN       = 3'd1;
    localparam logic [IDX_W-1:0] REG_SET      = 3'd2;
    localparam logic [IDX_W-1:0] REG_CLR      = 3'd3;
    localparam logic [IDX_W-1:0] REG_IRQ_EN   = 3'd4;
    localparam logic [IDX_W-1:0] REG_IRQ_EDGE = 3'd5;
    localparam logic [IDX_W-1:0] REG_IRQ_STAT = 3'd6;

    // 32-byte window: only address bits above bit 4 take part in the hit decode
    localparam logic [ADDR_W-1:0] ADDR_WIN_MASK = 32'hFFFF_FFE0;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
        logic [SEL_W-1:0]  sel;
        logic              we;
    } wb_req_t;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < SEL_W; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    // Inputs sit above the outputs and are tristated (oeb=1); outputs are driven
    function automatic logic [OEB_MAX_W-1:0] oeb_pattern(input int unsigned n_in,
                                                         input int unsigned n_out);
        logic [OEB_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < OEB_MAX_W; i++) begin
            if (i >= n_out && i < n_in + n_out) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_gpio_irq_input_cond.sv
// Input conditioning: 2-flop synchroniser per bit, optionally followed by a
// per-bit debouncer when GPIO_DEBOUNCE_EN is defined.
module gpio_input_cond
    import wb_gpio_pkg::*;
#(
    parameter int unsigned N               = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_async,
    output logic [N-1:0] o_in_q
);

    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
        $error("gpio_input_cond: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] r_cnt [N];
    logic [N-1:0]     r_in_q;

    // Counter tracks how long the synced value has disagreed with the accepted value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_in_q <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == r_in_q[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_in_q[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign o_in_q = r_in_q;
`else
    assign o_in_q = r_sync2;
`endif

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO slave with atomic set/clear, edge interrupts (W1C status) and
// optional input debouncing, enabled by defining GPIO_DEBOUNCE_EN.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDRESS    = 32'h3000_0000,
    parameter int unsigned       N_IN            = 8,
    parameter int unsigned       N_OUT           = 8,
    parameter int unsigned       DEBOUNCE_CYCLES = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [SEL_W-1:0]       wbs_sel_i,
    input  logic [ADDR_W-1:0]      wbs_adr_i,
    input  logic [DATA_W-1:0]      wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [DATA_W-1:0]      wbs_dat_o,
    input  logic [N_IN-1:0]        buttons,
    output logic [N_OUT-1:0]       leds,
    output logic                   irq,
    output logic [N_IN+N_OUT-1:0]  oeb
);

    if (N_IN < 1 || N_IN > 32 || N_OUT < 1 || N_OUT > 32) begin : g_cfg_err
        $error("wb_gpio_irq: N_IN and N_OUT must be within 1..32");
    end

    localparam logic [OEB_MAX_W-1:0] OEB_ALL = oeb_pattern(N_IN, N_OUT);

    wb_req_t           w_req;
    logic              w_hit;
    logic              w_access;
    logic              w_wr;
    logic              w_rd;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_wdat;
    logic              w_unused;

    logic              r_ack;
    logic [DATA_W-1:0] r_dat;
    logic [N_OUT-1:0]  r_out;
    logic [N_IN-1:0]   r_irq_en;
    logic [N_IN-1:0]   r_irq_edge;
    logic [N_IN-1:0]   r_irq_stat;
    logic [N_IN-1:0]   r_in_d;

    logic [N_OUT-1:0]  w_out_nxt;
    logic [N_IN-1:0]   w_irq_en_nxt;
    logic [N_IN-1:0]   w_irq_edge_nxt;
    logic [N_IN-1:0]   w_irq_stat_nxt;
    logic [N_IN-1:0]   w_w1c;
    logic [N_IN-1:0]   w_in_q;
    logic [N_IN-1:0]   w_rise;
    logic [N_IN-1:0]   w_fall;
    logic [N_IN-1:0]   w_evt;
    logic [DATA_W-1:0] w_out32;
    logic [DATA_W-1:0] w_rdata;

    // Bus decode; a held strobe is acknowledged every other cycle
    assign w_req    = '{adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i, we: wbs_we_i};
    assign w_hit    = wbs_cyc_i & wbs_stb_i &
                      ((w_req.adr & ADDR_WIN_MASK) == (BASE_ADDRESS & ADDR_WIN_MASK));
    assign w_access = w_hit & ~r_ack;
    assign w_wr     = w_access & w_req.we;
    assign w_rd     = w_access & ~w_req.we;
    assign w_idx    = w_req.adr[4:2];
    assign w_lane   = lane_mask(w_req.sel);
    assign w_wdat   = w_req.dat & w_lane;
    assign w_unused = ^w_req.adr[1:0];

    gpio_input_cond #(
        .N               (N_IN),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_input_cond (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_async (buttons),
        .o_in_q  (w_in_q)
    );

    assign w_rise = w_in_q & ~r_in_d;
    assign w_fall = ~w_in_q & r_in_d;
    assign w_evt  = (w_rise & r_irq_edge) | (w_fall & ~r_irq_edge);

    assign w_out32 = DATA_W'(r_out);

    // Register-file next state; byte lanes gated, bits above the register width dropped
    always_comb begin
        w_out_nxt      = r_out;
        w_irq_en_nxt   = r_irq_en;
        w_irq_edge_nxt = r_irq_edge;
        w_w1c          = '0;
        if (w_wr) begin
            case (w_idx)
                REG_OUT:      w_out_nxt      = N_OUT'((w_out32 & ~w_lane) | w_wdat);
                REG_SET:      w_out_nxt      = r_out | N_OUT'(w_wdat);
                REG_CLR:      w_out_nxt      = r_out & ~N_OUT'(w_wdat);
                REG_IRQ_EN:   w_irq_en_nxt   = N_IN'((DATA_W'(r_irq_en) & ~w_lane) | w_wdat);
                REG_IRQ_EDGE: w_irq_edge_nxt = N_IN'((DATA_W'(r_irq_edge) & ~w_lane) | w_wdat);
                REG_IRQ_STAT: w_w1c          = N_IN'(w_wdat);
                default:      ;
            endcase
        end
        // A fresh edge overrides a simultaneous clear of the same bit
        w_irq_stat_nxt = (r_irq_stat & ~w_w1c) | w_evt;
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            REG_OUT:      w_rdata = w_out32;
            REG_IN:       w_rdata = DATA_W'(w_in_q);
            REG_IRQ_EN:   w_rdata = DATA_W'(r_irq_en);
            REG_IRQ_EDGE: w_rdata = DATA_W'(r_irq_edge);
            REG_IRQ_STAT: w_rdata = DATA_W'(r_irq_stat);
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_out      <= '0;
            r_irq_en   <= '0;
            r_irq_edge <= '0;
            r_irq_stat <= '0;
            r_in_d     <= '0;
        end else begin
            r_ack      <= w_access;
            if (w_rd) begin
                r_dat <= w_rdata;
            end
            r_out      <= w_out_nxt;
            r_irq_en   <= w_irq_en_nxt;
            r_irq_edge <= w_irq_edge_nxt;
            r_irq_stat <= w_irq_stat_nxt;
            r_in_d     <= w_in_q;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign leds      = r_out;
    assign irq       = |(r_irq_stat & r_irq_en);
    assign oeb       = OEB_ALL[N_IN+N_OUT-1:0];

endmodule
